// File: rtl/pixel_fb_writer.sv
// AXI-stream pixel sink: accepts one raster-order frame per frame_start and
// writes channel-truncated pixels into a single-port framebuffer, one cycle after acceptance.
module pixel_fb_writer #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int CHAN_W = 4,
    parameter int ADDR_W = $clog2(H_RES*V_RES)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       frame_start,
    input  logic [23:0]                pixel_axis_tdata,
    input  logic                       pixel_axis_tvalid,
    output logic                       pixel_axis_tready,
    output logic [ADDR_W-1:0]          fb_addr,
    output logic [3*CHAN_W-1:0]        fb_data,
    output logic                       fb_we,
    output logic                       busy,
    output logic                       frame_done,
    output logic [$clog2(H_RES)-1:0]   cur_x,
    output logic [$clog2(V_RES)-1:0]   cur_y
);
    localparam int X_W = $clog2(H_RES);
    localparam int Y_W = $clog2(V_RES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    logic [1:0]            state_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic                  handshake;
    logic                  last_pix;
    logic [3*CHAN_W-1:0]   pix_trunc;
    logic                  unused_tdata;

    // Keep the top CHAN_W bits of each 8-bit channel; channel 0 is blue.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign pix_trunc[gi*CHAN_W +: CHAN_W] = pixel_axis_tdata[gi*8+7 -: CHAN_W];
    end
    assign unused_tdata = &{1'b0, pixel_axis_tdata};

    assign pixel_axis_tready = (state_reg == ACTIVE);
    assign busy              = (state_reg != IDLE);
    assign handshake         = pixel_axis_tvalid & pixel_axis_tready;
    assign last_pix          = (cur_x == X_LAST) && (cur_y == Y_LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= handshake;
            frame_done <= handshake && last_pix;
            if (handshake) begin
                fb_addr <= addr_reg;
                fb_data <= pix_trunc;
            end
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        state_reg <= ACTIVE;
                        addr_reg  <= '0;
                        cur_x     <= '0;
                        cur_y     <= '0;
                    end
                end
                ACTIVE: begin
                    if (handshake) begin
                        // Counters return to the origin after the last pixel.
                        if (last_pix) begin
                            state_reg <= DONE;
                            addr_reg  <= '0;
                            cur_x     <= '0;
                            cur_y     <= '0;
                        end else if (cur_x == X_LAST) begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                            cur_x    <= '0;
                            cur_y    <= cur_y + Y_W'(1);
                        end else begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                            cur_x    <= cur_x + X_W'(1);
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer on a 4x2 frame: vector table, directed
// corner sequences and randomized frames against a pixel-count reference model.
module tb_pixel_fb_writer;
    localparam int H = 4;
    localparam int V = 2;
    localparam int C = 4;
    localparam int A = 3;
    localparam int NPIX = H * V;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          frame_start = 1'b0;
    logic [23:0]   tdata = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [A-1:0]  fb_addr;
    logic [3*C-1:0] fb_data;
    logic          fb_we;
    logic          busy;
    logic          frame_done;
    logic [1:0]    cur_x;
    logic [0:0]    cur_y;

    pixel_fb_writer #(.H_RES(H), .V_RES(V), .CHAN_W(C), .ADDR_W(A)) dut (
        .aclk(aclk), .areset(areset), .frame_start(frame_start),
        .pixel_axis_tdata(tdata), .pixel_axis_tvalid(tvalid), .pixel_axis_tready(tready),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .busy(busy),
        .frame_done(frame_done), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;

    // Reference model: a frame is "pixels accepted so far" plus an active/done flag.
    bit m_active = 0;
    bit m_done = 0;
    int m_n = 0;
    int e_addr = 0;
    int e_data = 0;

    typedef struct {
        logic [23:0] tdata;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[NPIX];

    function automatic int trunc(input logic [23:0] d);
        int r, g, b;
        r = ((int'(d) >> 16) & 255) >> (8 - C);
        g = ((int'(d) >> 8) & 255) >> (8 - C);
        b = (int'(d) & 255) >> (8 - C);
        return (r << (2*C)) | (g << C) | b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_n = 0; e_addr = 0; e_data = 0;
    endtask

    // One clock cycle: drive inputs, predict, step the edge, compare, advance the model.
    task automatic cyc(input bit fs, input bit v, input logic [23:0] d);
        bit hs, last, was_idle, was_done;
        frame_start = fs; tvalid = v; tdata = d;
        hs = v && m_active;
        last = hs && (m_n == NPIX - 1);
        was_idle = !m_active && !m_done;
        was_done = m_done;
        @(posedge aclk); #1;
        if (hs) begin
            e_addr = m_n;
            e_data = trunc(d);
        end
        check("fb_we", int'(fb_we), int'(hs));
        check("fb_addr", int'(fb_addr), e_addr);
        check("fb_data", int'(fb_data), e_data);
        check("frame_done", int'(frame_done), int'(last));
        if (frame_done === 1'b1) fd_count++;
        if (hs) begin
            m_n++;
            if (m_n == NPIX) begin
                m_active = 0; m_done = 1; m_n = 0;
            end
        end else if (was_idle && fs) begin
            m_active = 1; m_n = 0;
        end
        if (was_done) m_done = 0;
        check("tready", int'(tready), int'(m_active));
        check("busy", int'(busy), int'(m_active || m_done));
        check("cur_x", int'(cur_x), m_n % H);
        check("cur_y", int'(cur_y), m_n / H);
        $display("cyc t=%0t fs=%0d v=%0d d=%06h hs=%0d we=%0d addr=%0d data=%03h done=%0d",
                 $time, fs, v, d, hs, fb_we, fb_addr, fb_data, frame_done);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, n, pending, k;
        logic [23:0] d;

        for (int i = 0; i < NPIX; i++) tbl[i].tdata = 24'hF0A53C + 24'(i);
        tbl[0].exp = 12'hFA3; tbl[1].exp = 12'hFA3; tbl[2].exp = 12'hFA3; tbl[3].exp = 12'hFA3;
        tbl[4].exp = 12'hFA4; tbl[5].exp = 12'hFA4; tbl[6].exp = 12'hFA4; tbl[7].exp = 12'hFA4;

        // Reset state
        #2;
        check("rst_tready", int'(tready), 0);
        check("rst_we", int'(fb_we), 0);
        check("rst_addr", int'(fb_addr), 0);
        check("rst_data", int'(fb_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_xy", int'({cur_x, cur_y}), 0);
        #21 areset = 1'b0;

        // 1: valid without frame_start is never accepted
        for (int i = 0; i < 20; i++) cyc(0, 1, 24'($urandom));

        // 2: back-to-back frame from the vector table
        fd0 = fd_count;
        cyc(1, 0, 24'h0);
        for (int i = 0; i < NPIX; i++) begin
            cyc(0, 1, tbl[i].tdata);
            check("tbl_data", int'(fb_data), int'(tbl[i].exp));
            check("tbl_addr", int'(fb_addr), i);
        end
        cyc(0, 0, 24'h0);
        check("t2_busy_after", int'(busy), 0);
        check("t2_done_count", fd_count - fd0, 1);

        // 3: tvalid pattern 1,0,0 repeating
        fd0 = fd_count;
        cyc(1, 0, 24'h0);
        n = 0;
        for (int i = 0; i < 40 && n < NPIX; i++) begin
            if (i % 3 == 0 && n == 3) check("t3_xy_before", int'({cur_x, cur_y}), 6);
            cyc(0, (i % 3) == 0, 24'($urandom));
            if (i % 3 == 0) begin
                n++;
                if (n == 4) check("t3_xy_after", int'({cur_x, cur_y}), 1);
            end
        end
        cyc(0, 0, 24'h0);
        check("t3_done_count", fd_count - fd0, 1);

        // 4: frame_start during an active frame is ignored
        fd0 = fd_count;
        cyc(1, 0, 24'h0);
        for (int i = 0; i < NPIX; i++) cyc(i == 3, 1, 24'($urandom));
        cyc(0, 0, 24'h0);
        cyc(0, 0, 24'h0);
        check("t4_done_count", fd_count - fd0, 1);

        // 5: asynchronous reset mid-frame after pixel 5
        fd0 = fd_count;
        cyc(1, 0, 24'h0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 24'($urandom));
        #3 areset = 1'b1;
        #1;
        check("t5_tready", int'(tready), 0);
        check("t5_we", int'(fb_we), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(frame_done), 0);
        model_reset();
        @(posedge aclk); #1;
        check("t5_we_hold", int'(fb_we), 0);
        check("t5_done_hold", int'(frame_done), 0);
        #2 areset = 1'b0;
        check("t5_no_done", fd_count - fd0, 0);
        cyc(1, 0, 24'h0);
        cyc(0, 1, 24'h123456);
        check("t5_restart_addr", int'(fb_addr), 0);
        for (int i = 1; i < NPIX; i++) cyc(0, 1, 24'($urandom));
        cyc(0, 0, 24'h0);

        // 6: ten pixels offered with tvalid held high
        cyc(1, 0, 24'h0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            d = 24'h010101 * 24'(k + 1);
            if (m_active) k++;
            cyc(0, k < 10 || !m_active, d);
        end
        pending = 10 - k;
        check("t6_pending", pending, 2);
        check("t6_tready", int'(tready), 0);

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            fd0 = fd_count;
            cyc(1, 0, 24'h0);
            for (int i = 0; i < 200 && (m_active || m_done); i++)
                cyc(0, 1'($urandom_range(0, 1)), 24'($urandom));
            check("rand_done_count", fd_count - fd0, 1);
            for (int i = 0; i < 3; i++) cyc(0, 1'($urandom_range(0, 1)), 24'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixel_fb_writer.md
Name: pixel_fb_writer

Overview:
- AXI-stream sink for the shader's 24-bit pixel output stream; the receiving end of the pixel interface.
- Accepts pixels in raster order (x fastest, then y) and writes each one into a single-port framebuffer BRAM.
- Each pixel is truncated to CHAN_W bits per channel before it is written.
- Runs one frame per frame_start and pulses frame_done after the last pixel has been written, so the render controller can swap or scan out the buffer.

Parameters:
- H_RES, 320, horizontal resolution in pixels.
- V_RES, 240, vertical resolution in pixels.
- CHAN_W, 4, bits kept per colour channel (MSBs of each 8-bit channel); range 1..8.
- ADDR_W, $clog2(H_RES*V_RES), framebuffer address width.

Ports:
- aclk, input, 1, clock; all logic is on the rising edge.
- areset, input, 1, asynchronous, active-high reset.
- frame_start, input, 1, single-cycle request to begin a frame.
- pixel_axis_tdata, input, 24, pixel: [23:16]=R, [15:8]=G, [7:0]=B.
- pixel_axis_tvalid, input, 1, upstream pixel valid.
- pixel_axis_tready, output, 1, this block accepts a pixel.
- fb_addr, output, ADDR_W, framebuffer write address.
- fb_data, output, 3*CHAN_W, packed {R,G,B} MSBs.
- fb_we, output, 1, framebuffer write enable.
- busy, output, 1, a frame is in progress.
- frame_done, output, 1, one-cycle pulse when the frame completes.
- cur_x, output, $clog2(H_RES), x coordinate of the next expected pixel.
- cur_y, output, $clog2(V_RES), y coordinate of the next expected pixel.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - pixel_axis_tready=0, fb_we=0, fb_addr=0, fb_data=0.
  - busy=0, frame_done=0, cur_x=0, cur_y=0, linear address counter=0.
  - Reset asserted mid-frame abandons the frame: no further writes, and no frame_done for that frame.
- States:
  - IDLE -> ACTIVE on frame_start. cur_x, cur_y and the address counter clear to 0 on that edge.
  - ACTIVE -> DONE on the handshake of the pixel at (H_RES-1, V_RES-1).
  - DONE -> IDLE unconditionally after one cycle.
- pixel_axis_tready is high exactly when state==ACTIVE. It is a registered-state decode and never depends combinationally on tvalid.
- A handshake is pixel_axis_tvalid & pixel_axis_tready in the same cycle.
- On a handshake at address A, the next cycle has:
  - fb_we=1
  - fb_addr=A
  - fb_data={tdata[23:24-CHAN_W], tdata[15:16-CHAN_W], tdata[7:8-CHAN_W]}
- Write latency is exactly 1 cycle. fb_we is 0 in every cycle that does not follow a handshake.
- fb_addr and fb_data hold their last values when fb_we=0.
- Counters advance only on a handshake:
  - cur_x increments; at H_RES-1 it wraps to 0 and cur_y increments.
  - The address counter increments by 1, so address = cur_y*H_RES + cur_x with no multiplier.
- Backpressure and bubbles: tvalid low for any number of cycles simply stalls; the counters hold.
- Last pixel:
  - pixel_axis_tready falls in the cycle after its handshake; state=DONE in that cycle.
  - In that same cycle fb_we=1 for address H_RES*V_RES-1 and frame_done=1.
- busy=1 in ACTIVE and DONE, and 0 in IDLE.
- frame_start is ignored in ACTIVE and DONE; it does not restart the frame. A frame_start in the DONE cycle is lost. The controller must reissue it once busy=0.
- Pixels offered while in IDLE or DONE are not accepted (tready=0). Upstream holds tvalid per AXI rules.
- Frames shorter than H_RES*V_RES pixels never complete. Recovery is only by reset.

Test Plan:
Bench configuration: H_RES=4, V_RES=2, CHAN_W=4, ADDR_W=3.
1. Reset, then drive tvalid=1 without frame_start -> tready stays 0, fb_we stays 0 and busy stays 0 for 20 cycles.
2. frame_start, then stream 8 pixels back-to-back with tdata=24'hF0A5_3C + i -> fb_we high 8 consecutive cycles, addresses 0..7, first fb_data=12'hFA3. frame_done pulses exactly once, coincident with the address-7 write. busy=0 the cycle after.
3. Same frame with tvalid toggling 1,0,0,1,... -> writes occur only one cycle after each handshake. Addresses are still 0..7 in order. cur_x/cur_y read (3,0) before the 4th handshake, then (0,1) after it.
4. Assert frame_start at pixel 3 of an active frame -> it is ignored. Addresses continue 4..7 and there is a single frame_done.
5. Assert areset asynchronously (mid-cycle) after pixel 5 -> tready, fb_we and busy drop immediately with no frame_done. A new frame_start then rewrites from address 0.
6. Hold tvalid=1 with 10 pixels available -> only 8 are accepted. tready=0 from the cycle after the 8th handshake, and pixels 9-10 remain pending upstream.
